// File: rtl/crc_sched_pkg.sv
// Shared types and helpers for the round-robin CRC engine scheduler.
package crc_sched_pkg;

  localparam int MAX_NREQ = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // One-hot vector with bit id set; callers size-cast down to their own width.
  function automatic logic [MAX_NREQ-1:0] onehot(input int id, input int n);
    logic [MAX_NREQ-1:0] v;
    v = '0;
    if (id >= 0 && id < n && id < MAX_NREQ) v[id[3:0]] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/crc_sched_if.sv
// Request/ready/valid bus between the scheduler (master) and the serial CRC engine (slave).
interface crc_sched_if #(
  parameter int DW = 8,
  parameter int CW = 8
);
  logic          eng_req;
  logic [DW-1:0] eng_din;
  logic          eng_ready;
  logic          eng_valid;
  logic [CW-1:0] eng_crc;

  modport master (output eng_req, eng_din, input eng_ready, eng_valid, eng_crc);
  modport slave  (input eng_req, eng_din, output eng_ready, eng_valid, eng_crc);
endinterface

// File: rtl/crc_sched_rr_arb.sv
// Combinational rotate-priority encoder: first set request at or above ptr, wrapping at N.
module rr_arb #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          gnt_vld,
  output logic [IW-1:0] gnt_id
);

  int idx;

  // Scan from the farthest offset down so the nearest set bit to ptr wins last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (req[idx[IW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/crc_sched.sv
// Round-robin scheduler sharing one serial CRC engine among NREQ requesters.
// Optional job timeout in BUSY is enabled by defining CRC_SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbitrate; latch winner id and data
// ISSUE | present job to engine, wait for eng_ready
// BUSY  | wait for engine result (or timeout)
// RESP  | one-cycle response strobe to the winner
module crc_sched
  import crc_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int TMO  = 64
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [CW-1:0]      rsp_crc,
  output logic               rsp_err,
  crc_sched_if.master        eng
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state, state_nxt;
  logic [IW-1:0]   ptr, gid, gnt_id, ptr_inc;
  logic [DW-1:0]   dreg, din_sel;
  logic [NREQ-1:0] gid_oh;
  logic            gnt_vld, accept, tmo_hit;

  rr_arb #(.N(NREQ)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign din_sel = din[int'(gnt_id)*DW +: DW];
  assign ptr_inc = (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
  assign gid_oh  = NREQ'(onehot(int'(gid), NREQ));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE:  if (gnt_vld) state_nxt = ISSUE;
      ISSUE: begin
        if (eng.eng_ready) begin
          accept    = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY:  if (eng.eng_valid || tmo_hit) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign eng.eng_req = (state == ISSUE);
  assign eng.eng_din = (state == ISSUE) ? dreg : '0;
  assign ack         = accept ? gid_oh : '0;
  assign rsp_valid   = (state == RESP) ? gid_oh : '0;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr     <= '0;
      gid     <= '0;
      dreg    <= '0;
      rsp_crc <= '0;
    end else begin
      if (state == IDLE && gnt_vld) begin
        gid  <= gnt_id;
        dreg <= din_sel;
      end
      if (accept) ptr <= ptr_inc;
      // A real result takes precedence over a timeout landing in the same cycle.
      if (state == BUSY && eng.eng_valid) rsp_crc <= eng.eng_crc;
      else if (state == BUSY && tmo_hit)  rsp_crc <= '0;
    end
  end

`ifdef CRC_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO + 1);

  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  assign tmo_hit = (tmo_cnt == TW'(TMO - 1));
  assign rsp_err = (state == RESP) && err_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept)                        tmo_cnt <= '0;
      else if (state == BUSY && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
      if (state == BUSY) err_q <= tmo_hit && !eng.eng_valid;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_crc_sched.sv
// Self-checking bench for crc_sched: behavioural engine, transaction-level model, random + directed jobs.
module tb_crc_sched;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int CW   = 8;
  localparam int TMO  = 16;
`ifdef CRC_SCHED_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic               clk   = 1'b0;
  logic               rst_b = 1'b1;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    ack, rsp_valid;
  logic [CW-1:0]      rsp_crc;
  logic               rsp_err;

  crc_sched_if #(.DW(DW), .CW(CW)) eng ();

  crc_sched #(.NREQ(NREQ), .DW(DW), .CW(CW), .TMO(TMO)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .rsp_valid (rsp_valid),
    .rsp_crc   (rsp_crc),
    .rsp_err   (rsp_err),
    .eng       (eng)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [CW-1:0] crc8(input logic [DW-1:0] d);
    logic [7:0] c;
    c = d;
    for (int b = 0; b < 8; b++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // stimulus knobs and requester state
  logic [DW-1:0]   din_a[NREQ], din_n[NREQ];
  logic [NREQ-1:0] req_n = '0;
  bit auto_req = 0, hold_mode = 0, spur_en = 0, ready_rand = 0, ready_val = 1, eng_mute = 0;
  int lat_min = 0, lat_max = 0;

  // engine model
  bit            eng_busy = 0, eng_acc = 0;
  int            eng_cnt = 0;
  logic [DW-1:0] eng_data, acc_data;

  // reference model of the job flow
  bit            job_open = 0, acked = 0, vseen = 0, exp_err = 0;
  int            cur_id = 0, issue_at = 0, ack_c = 0, rsp_at = -1, earliest = 0, ptr_m = 0;
  int            last_ack_cyc = 0;
  logic [DW-1:0] cur_din;
  logic [CW-1:0] exp_crc;
  int            grants[$];
  logic [CW-1:0] rsps[$];
  bit            errs[$];

  task automatic apply_inputs();
    for (int i = 0; i < NREQ; i++) begin
      din_a[i] = din_n[i];
      din[i*DW +: DW] = din_n[i];
    end
    req = req_n;
    eng.eng_valid = 1'b0;
    eng.eng_crc   = CW'($urandom);
    if (eng_acc) begin
      eng_busy = 1;
      eng_cnt  = $urandom_range(lat_max, lat_min);
      eng_data = acc_data;
      eng_acc  = 0;
    end
    if (eng_busy) begin
      if (eng_cnt == 0) begin
        eng.eng_valid = !eng_mute;
        eng.eng_crc   = crc8(eng_data);
        eng_busy      = 0;
      end else eng_cnt--;
    end else if (spur_en && $urandom_range(7, 0) == 0) begin
      eng.eng_valid = 1'b1;
      eng.eng_crc   = 8'hAA;
    end
    eng.eng_ready = !eng_busy && (ready_rand ? ($urandom_range(3, 0) != 0) : ready_val);
  endtask

  task automatic check_cycle();
    bit              exp_issue;
    logic [NREQ-1:0] exp_ack, exp_rsp;
    exp_issue = job_open && !acked && (cyc >= issue_at);
    check("eng_req", eng.eng_req, exp_issue);
    if (exp_issue) check("eng_din", eng.eng_din, cur_din);
    exp_ack = '0;
    if (exp_issue && eng.eng_ready) exp_ack[cur_id] = 1'b1;
    check("ack", ack, exp_ack);
    exp_rsp = '0;
    if (job_open && cyc == rsp_at) exp_rsp[cur_id] = 1'b1;
    check("rsp_valid", rsp_valid, exp_rsp);
    if (exp_rsp != 0) begin
      check("rsp_crc", rsp_crc, exp_crc);
      check("rsp_err", rsp_err, exp_err);
      job_open = 0;
      rsp_at   = -1;
      earliest = cyc + 1;
    end
    if (rsp_valid != 0) begin
      rsps.push_back(rsp_crc);
      errs.push_back(rsp_err);
    end
    for (int i = 0; i < NREQ; i++) if (ack[i]) grants.push_back(i);
    if (job_open && acked && !vseen) begin
      if (eng.eng_valid) begin
        vseen = 1; rsp_at = cyc + 1; exp_crc = crc8(cur_din); exp_err = 0;
      end else if (TMO_EN && cyc == ack_c + TMO) begin
        vseen = 1; rsp_at = cyc + 1; exp_crc = '0; exp_err = 1;
      end
    end
    if (exp_ack != 0) begin
      acked = 1; ack_c = cyc; last_ack_cyc = cyc; ptr_m = (cur_id + 1) % NREQ;
    end
    if (!job_open && cyc >= earliest && req != 0) begin
      cur_id = rr_pick(req, ptr_m); cur_din = din_a[cur_id];
      job_open = 1; acked = 0; vseen = 0; issue_at = cyc + 1;
    end
    if (eng.eng_req && eng.eng_ready) begin
      eng_acc = 1; acc_data = eng.eng_din;
    end
    // requesters decide what they present next cycle
    for (int i = 0; i < NREQ; i++) begin
      req_n[i] = req[i];
      din_n[i] = din_a[i];
      if (ack[i]) begin
        if (hold_mode) ;
        else if (auto_req && $urandom_range(1, 0) == 1) din_n[i] = DW'($urandom);
        else req_n[i] = 1'b0;
      end else if (!req[i] && auto_req && $urandom_range(3, 0) == 0) begin
        req_n[i] = 1'b1;
        din_n[i] = DW'($urandom);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    apply_inputs();
    #1;
    check_cycle();
  endtask

  task automatic set_req(input int i, input logic v, input logic [DW-1:0] d);
    req_n[i] = v;
    din_n[i] = d;
  endtask

  task automatic drain(input int budget);
    while ((job_open || req != 0 || req_n != 0) && budget > 0) begin
      step();
      budget--;
    end
    check("drain_done", job_open, 1'b0);
  endtask

  task automatic wait_grants(input int n, input int budget);
    while (grants.size() < n && budget > 0) begin
      step();
      budget--;
    end
    check("grant_count", grants.size(), n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ack"}, ack, '0);
    check({tag, "_rsp_valid"}, rsp_valid, '0);
    check({tag, "_rsp_crc"}, rsp_crc, '0);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_eng_req"}, eng.eng_req, 1'b0);
    check({tag, "_eng_din"}, eng.eng_din, '0);
  endtask

  initial begin
    int exp_g2[5] = '{0, 1, 2, 3, 0};
    int exp_c2[5] = '{8'h00, 8'h07, 8'h97, 8'h00, 8'h00};
    int exp_g3[4] = '{2, 3, 2, 3};
    int req_cyc, b;
    req = '0; din = '0;
    for (int i = 0; i < NREQ; i++) begin din_a[i] = '0; din_n[i] = '0; end
    eng.eng_ready = 1'b0; eng.eng_valid = 1'b0; eng.eng_crc = '0;

    #2 rst_b = 1'b0;
    #1 check_outputs_zero("reset");
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    earliest = cyc + 1;

    // contention: all four held, grant order 0,1,2,3,0 with ptr wrap
    hold_mode = 1; ready_val = 1; lat_min = 0; lat_max = 2;
    set_req(0, 1, 8'h00); set_req(1, 1, 8'h01); set_req(2, 1, 8'h31); set_req(3, 1, 8'h00);
    grants.delete(); rsps.delete();
    wait_grants(5, 200);
    req_n = '0;
    drain(100);
    hold_mode = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < grants.size()) check("t2_grant", grants[k], exp_g2[k]);
      if (k < rsps.size())   check("t2_crc", rsps[k], exp_c2[k]);
    end

    // fairness between two permanently active requesters
    hold_mode = 1;
    grants.delete();
    set_req(2, 1, 8'h12); set_req(3, 1, 8'h34);
    wait_grants(4, 200);
    req_n = '0;
    drain(100);
    hold_mode = 0;
    for (int k = 0; k < 4 && k < grants.size(); k++) check("t3_grant", grants[k], exp_g3[k]);

    // single job, ack one cycle after req
    grants.delete(); rsps.delete();
    set_req(0, 1, 8'h31);
    step();
    req_cyc = cyc;
    drain(100);
    check("t1_ack_lat", last_ack_cyc - req_cyc, 1);
    check("t1_rsp_cnt", rsps.size(), 1);
    if (rsps.size() > 0) check("t1_crc", rsps[0], 8'h97);

    // backpressure: engine not ready for 12 cycles
    grants.delete();
    ready_val = 0;
    set_req(1, 1, 8'h5A);
    repeat (12) step();
    check("t4_no_ack", grants.size(), 0);
    ready_val = 1;
    step();
    check("t4_ack", ack, 4'b0010);
    drain(100);

    // reset while BUSY
    grants.delete(); rsps.delete();
    lat_min = 20; lat_max = 20;
    set_req(1, 1, 8'h77);
    b = 20;
    while (!acked && b > 0) begin step(); b--; end
    check("t5_acked", acked, 1'b1);
    repeat (3) step();
    #2 rst_b = 1'b0;
    #1 check_outputs_zero("t5_async");
    job_open = 0; acked = 0; vseen = 0; rsp_at = -1; ptr_m = 0;
    eng_busy = 0; eng_acc = 0; req_n = '0; req = '0;
    eng.eng_ready = 1'b0; eng.eng_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    earliest = cyc + 1;
    lat_min = 0; lat_max = 3;
    repeat (5) step();
    check("t5_no_rsp", rsps.size(), 0);
    grants.delete();
    set_req(1, 1, 8'h01);
    drain(100);
    check("t5_grant_cnt", grants.size(), 1);
    if (grants.size() > 0) check("t5_grant", grants[0], 1);
    if (rsps.size() > 0) check("t5_crc", rsps[0], 8'h07);

`ifdef CRC_SCHED_TIMEOUT_EN
    // engine never answers, then answers too late
    rsps.delete(); errs.delete();
    eng_mute = 1; lat_min = 30; lat_max = 30;
    set_req(2, 1, 8'h31);
    drain(100);
    repeat (20) step();
    eng_mute = 0; lat_min = TMO + 4; lat_max = TMO + 4;
    set_req(3, 1, 8'h01);
    drain(100);
    repeat (10) step();
    check("t6_rsp_cnt", rsps.size(), 2);
    for (int k = 0; k < 2 && k < rsps.size(); k++) begin
      check("t6_err", errs[k], 1'b1);
      check("t6_crc", rsps[k], 8'h00);
    end
    lat_min = 0; lat_max = 3;
`endif

    // randomized traffic
    grants.delete(); rsps.delete();
    auto_req = 1; ready_rand = 1; spur_en = 1; lat_min = 0; lat_max = 5;
    repeat (3000) step();
    auto_req = 0; spur_en = 0;
    drain(300);
    check("rand_jobs_balanced", rsps.size(), grants.size());
    check("rand_activity", grants.size() > 100, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
